// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response and word-memory port of the load/store unit
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we_n;
  logic [31:0] mem_rd;
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, mem_a, mem_wd, mem_we_n
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, mem_a, mem_wd, mem_we_n
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte/half/word loads and stores at any alignment over a word-wide memory
module lsu_ctrl #(
  parameter int N = 12
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD0, LD1, SR0, SW0, SR1, SW1, RESP} state_t;
  state_t      state, state_d;
  logic        we, uns, straddle;
  logic [1:0]  size, off;
  logic [31:0] addr, wdata, buf0, buf1, rsp_q, ext;
  logic [N-1:0] w0, w1;
  logic [63:0] old, v, d, merged;
  logic [7:0]  m;
  assign off      = addr[1:0];
  assign w0       = addr[N+1:2];
  assign w1       = w0 + N'(1);
  assign straddle = size == 2'b01 ? off == 2'd3 : size != 2'b00 && off != 2'd0;
  assign old      = {buf1, buf0};
  assign v        = old >> {off, 3'b000};
  assign ext      = size == 2'b00 ? {{24{~uns & v[7]}}, v[7:0]} :
                    size == 2'b01 ? {{16{~uns & v[15]}}, v[15:0]} : v[31:0];
  assign m        = (size == 2'b00 ? 8'h01 : size == 2'b01 ? 8'h03 : 8'h0f) << off;
  assign d        = {32'b0, wdata} << {off, 3'b000};
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign merged[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = !bus.req_valid ? IDLE : bus.req_we ? SR0 : LD0;
      LD0:     state_d = straddle ? LD1 : RESP;
      LD1:     state_d = RESP;
      SR0:     state_d = SW0;
      SW0:     state_d = straddle ? SR1 : RESP;
      SR1:     state_d = SW1;
      SW1:     state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = state == RESP ? (we ? 32'b0 : ext) : rsp_q;
    bus.mem_a     = state inside {LD1, SR1, SW1} ? {{(32-N){1'b0}}, w1} :
                    state inside {LD0, SR0, SW0} ? {{(32-N){1'b0}}, w0} : 32'b0;
    bus.mem_wd    = state == SW0 ? merged[31:0] : state == SW1 ? merged[63:32] : 32'b0;
    bus.mem_we_n  = !(state inside {SW0, SW1});
  end
  // rsp_q keeps the last response visible once RESP has passed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we    <= 1'b0;
      uns   <= 1'b0;
      size  <= 2'b0;
      addr  <= 32'b0;
      wdata <= 32'b0;
      buf0  <= 32'b0;
      buf1  <= 32'b0;
      rsp_q <= 32'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.req_valid) begin
        we    <= bus.req_we;
        uns   <= bus.req_unsigned;
        size  <= bus.req_size;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
      end
      if (state inside {LD0, SR0}) buf0 <= bus.mem_rd;
      if (state inside {LD1, SR1}) buf1 <= bus.mem_rd;
      if (state == RESP) rsp_q <= bus.rsp_rdata;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: vector table, reset/wrap/back-to-back sequences and random ops vs a byte-level model
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nchk = 0;
  int nerr = 0;
  logic [31:0] emem [0:4095];
  logic [31:0] rmem [0:4095];
  lsu_ctrl_if bus();
  lsu_ctrl #(.N(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rd = emem[bus.mem_a[11:0]];
  always @(posedge clk) if (!bus.mem_we_n) emem[bus.mem_a[11:0]] <= bus.mem_wd;
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    int          nw;
    logic [31:0] w10;
    logic [31:0] w11;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] r = 32'b0;
    logic [31:0] ba;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      r[8*i +: 8] = rmem[ba[13:2]][8*ba[1:0] +: 8];
    end
    if (!u && n == 1) r = {{24{r[7]}}, r[7:0]};
    if (!u && n == 2) r = {{16{r[15]}}, r[15:0]};
    return r;
  endfunction
  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] ba;
    for (int i = 0; i < nbytes(sz); i++) begin
      ba = a + 32'(i);
      rmem[ba[13:2]][8*ba[1:0] +: 8] = wd[8*i +: 8];
    end
  endtask
  function automatic int ref_lat(input logic we, input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] last = a + 32'(nbytes(sz) - 1);
    bit s = last[13:2] != a[13:2];
    return we ? (s ? 5 : 3) : (s ? 3 : 2);
  endfunction
  task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] rd, output int lat,
                        output int nw, output int waits, output int rdyhi,
                        output logic [31:0] a0, output logic [31:0] a1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = u;
    bus.req_addr = a;
    bus.req_wdata = wd;
    waits = 0;
    while (!bus.req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.req_ready) chk("accept_timeout", 32'(waits), 32'(0));
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    lat = 0; nw = 0; rdyhi = 0; rd = 32'hx; a0 = 32'hx; a1 = 32'hx;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) a0 = bus.mem_a;
      if (c == 2) a1 = bus.mem_a;
      if (!bus.mem_we_n) nw++;
      if (bus.req_ready) rdyhi++;
      if (bus.rsp_valid) begin
        lat = c;
        rd = bus.rsp_rdata;
        break;
      end
    end
    if (lat == 0) chk("rsp_timeout", 32'(lat), 32'(1));
  endtask
  task automatic preload();
    emem[12'h010] = 32'h88776655; rmem[12'h010] = 32'h88776655;
    emem[12'h011] = 32'hCCBBAA99; rmem[12'h011] = 32'hCCBBAA99;
  endtask
  initial begin
    logic [31:0] rd, a0, a1, exp, held, x, ad;
    int lat, nw, waits, rdyhi, cnt;
    logic we, u;
    logic [1:0] sz;
    for (int i = 0; i < 4096; i++) begin
      x = $urandom;
      emem[i] = x;
      rmem[i] = x;
    end
    preload();
    tbl[0] = '{1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 32'hFFFFFF88, 2, 0, 32'h88776655, 32'hCCBBAA99};
    tbl[1] = '{1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 32'h00000088, 2, 0, 32'h88776655, 32'hCCBBAA99};
    tbl[2] = '{1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 32'hAA998877, 3, 0, 32'h88776655, 32'hCCBBAA99};
    tbl[3] = '{1'b0, 2'd1, 1'b0, 32'h43, 32'h0, 32'hFFFF9988, 3, 0, 32'h88776655, 32'hCCBBAA99};
    tbl[4] = '{1'b0, 2'd1, 1'b1, 32'h41, 32'h0, 32'h00007766, 2, 0, 32'h88776655, 32'hCCBBAA99};
    tbl[5] = '{1'b1, 2'd0, 1'b0, 32'h41, 32'hEE, 32'h0, 3, 1, 32'h8877EE55, 32'hCCBBAA99};
    tbl[6] = '{1'b1, 2'd2, 1'b0, 32'h43, 32'h11223344, 32'h0, 5, 2, 32'h4477EE55, 32'hCC112233};
    tbl[7] = '{1'b0, 2'd3, 1'b0, 32'h44, 32'h0, 32'hCC112233, 2, 0, 32'h4477EE55, 32'hCC112233};
    tbl[8] = '{1'b1, 2'd1, 1'b0, 32'h43, 32'hBEEF, 32'h0, 5, 2, 32'hEF77EE55, 32'hCC1122BE};
    tbl[9] = '{1'b0, 2'd1, 1'b1, 32'h43, 32'h0, 32'h0000BEEF, 3, 0, 32'hEF77EE55, 32'hCC1122BE};
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_we_n", 32'(bus.mem_we_n), 32'(1));
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      exp = tbl[i].we ? 32'h0 : ref_load(tbl[i].a, tbl[i].sz, tbl[i].u);
      do_req(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, 1'b0, rd, lat, nw, waits, rdyhi, a0, a1);
      if (tbl[i].we) ref_store(tbl[i].a, tbl[i].sz, tbl[i].wd);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_model", i), rd, exp);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_writes", i), 32'(nw), 32'(tbl[i].nw));
      chk($sformatf("tbl%0d_busy_ready", i), 32'(rdyhi), 32'(0));
      chk($sformatf("tbl%0d_w10", i), emem[12'h010], tbl[i].w10);
      chk($sformatf("tbl%0d_w11", i), emem[12'h011], tbl[i].w11);
      held = rd;
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), 32'(bus.rsp_valid), 32'(0));
      chk($sformatf("tbl%0d_hold", i), bus.rsp_rdata, held);
    end
    preload();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h43; bus.req_wdata = 32'h11223344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_seq_sw0_we_n", 32'(bus.mem_we_n), 32'(0));
    @(negedge clk);
    chk("rst_seq_sr1_addr", bus.mem_a, 32'h11);
    chk("rst_seq_sr1_we_n", 32'(bus.mem_we_n), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_seq_async_we_n", 32'(bus.mem_we_n), 32'(1));
    chk("rst_seq_async_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_seq_async_mem_a", bus.mem_a, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.mem_we_n) cnt++;
    end
    chk("rst_seq_no_activity", 32'(cnt), 32'(0));
    chk("rst_seq_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_seq_w10", emem[12'h010], 32'h44776655);
    chk("rst_seq_w11", emem[12'h011], 32'hCCBBAA99);
    preload();
    emem[12'hFFF] = 32'hDDCCBBAA; rmem[12'hFFF] = 32'hDDCCBBAA;
    emem[12'h000] = 32'h44332211; rmem[12'h000] = 32'h44332211;
    do_req(1'b0, 2'd2, 1'b0, 32'h3FFE, 32'h0, 1'b1, rd, lat, nw, waits, rdyhi, a0, a1);
    chk("wrap_rdata", rd, 32'h2211DDCC);
    chk("wrap_first_a", a0, 32'hFFF);
    chk("wrap_second_a", a1, 32'h0);
    chk("wrap_lat", 32'(lat), 32'(3));
    chk("wrap_busy_ready", 32'(rdyhi), 32'(0));
    do_req(1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 1'b0, rd, lat, nw, waits, rdyhi, a0, a1);
    chk("b2b_bubble", 32'(waits), 32'(1));
    chk("b2b_rdata", rd, 32'h00000055);
    chk("b2b_lat", 32'(lat), 32'(2));
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom);
      sz = 2'($urandom);
      u = 1'($urandom);
      ad = ($urandom_range(0, 7) == 0) ? 32'h3FF0 + $urandom_range(0, 15) : 32'h40 + $urandom_range(0, 31);
      ad[31:14] = 18'($urandom);
      x = $urandom;
      exp = we ? 32'h0 : ref_load(ad, sz, u);
      do_req(we, sz, u, ad, x, 1'b0, rd, lat, nw, waits, rdyhi, a0, a1);
      chk($sformatf("rnd%0d_rdata", k), rd, exp);
      chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(ref_lat(we, ad, sz)));
      chk($sformatf("rnd%0d_writes", k), 32'(nw), 32'(!we ? 0 : ref_lat(we, ad, sz) == 5 ? 2 : 1));
      if (we) begin
        ref_store(ad, sz, x);
        chk($sformatf("rnd%0d_w0", k), emem[ad[13:2]], rmem[ad[13:2]]);
        chk($sformatf("rnd%0d_w1", k), emem[ad[13:2] + 12'd1], rmem[ad[13:2] + 12'd1]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting between the core's execute stage and the word-wide data memory. It turns byte, halfword and word requests at any byte alignment into word-index read and write cycles on the memory port. Sub-word stores are done as read-modify-write, and accesses that straddle two words are split into two word accesses. Loads are returned sign- or zero-extended, with a one-cycle response pulse.

Parameters:
N, 12, memory word-index width; mem_a carries a word index wrapped modulo 2**N, zero-extended to 32 bits.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word; 11 decoded as word
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse, no back-pressure
rsp_rdata  out  32  load result; 0 for stores
mem_a  out  32  word index to data memory
mem_wd  out  32  merged write word
mem_we_n  out  1  memory write strobe, active-low: 0 = write this cycle
mem_rd  in  32  combinational read data for mem_a

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, mem_we_n=1, mem_a=0, mem_wd=0.
  - Effect is immediate, including mid-operation. A pending write is never issued and no response is produced.
- Accept: req_valid && req_ready at a clock edge.
  - Registers we, size, unsigned, addr, wdata.
  - w0 = addr[N+1:2]; w1 = (w0+1) mod 2**N (wraps from 2**N-1 to 0).
- Straddle condition: half with addr[1:0]==3, or word with addr[1:0]!=0. Bytes never straddle.
- FSM states: IDLE, LD0, LD1, SR0, SW0, SR1, SW1, RESP.
  - Load: IDLE -> LD0 -> (LD1 if straddle) -> RESP -> IDLE.
  - Store: IDLE -> SR0 -> SW0 -> (SR1 -> SW1 if straddle) -> RESP -> IDLE.
  - LD0 and SR0 drive mem_a=w0 and capture mem_rd into buf0 at the edge.
  - LD1 and SR1 drive mem_a=w1 and capture mem_rd into buf1.
  - SW0 drives mem_a=w0, mem_wd=merged buf0, mem_we_n=0.
  - SW1 drives mem_a=w1, mem_wd=merged buf1, mem_we_n=0.
  - mem_we_n=1 in every other state. Full-word aligned stores still perform SR0 (uniform path).
- Latency, counted from the accept edge to rsp_valid high:
  - Aligned load: 2 cycles. Straddling load: 3.
  - Aligned store: 3 cycles. Straddling store: 5.
- RESP: rsp_valid=1 for exactly one cycle. rsp_rdata is valid only in that cycle and holds its value afterwards. req_ready=0 during RESP and returns to 1 the cycle after, so back-to-back requests have a 1-cycle bubble.
- Load extract:
  - Form V = {buf1, buf0} (64 bits, little-endian lanes; buf1 ignored if not straddling).
  - Shift right by 8*addr[1:0] and take the low 8, 16 or 32 bits.
  - Extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Store merge:
  - Byte mask M = (1,3,F for size) << addr[1:0], over 8 lanes.
  - Data D = {32'b0, wdata} << 8*addr[1:0].
  - Lanes with M set take D; all other lanes keep the buffered value.
  - Low 4 lanes go to word w0, high 4 lanes to word w1.
- req_valid while busy is ignored; the request must be held by the core until req_ready.

Test Plan:
Preload memory: word 0x10 = 0x88776655, word 0x11 = 0xCCBBAA99.
1. Byte loads at addr 0x43: LB -> rsp_rdata 0xFFFFFF88; LBU -> 0x00000088. rsp_valid pulses 2 cycles after accept, mem_we_n stays 1.
2. LW at addr 0x42 -> mem_a reads 0x10 then 0x11, rsp_rdata 0xAA998877 at 3 cycles. LH signed at 0x43 -> 0xFFFF9988.
3. SB at addr 0x41, wdata 0x000000EE -> exactly one mem_we_n=0 cycle, word 0x10 = 0x8877EE55, word 0x11 unchanged, rsp_rdata 0.
4. SW at addr 0x43, wdata 0x11223344 -> two write cycles, word 0x10 = 0x44776655, word 0x11 = 0xCC112233, rsp_valid at 5 cycles.
5. Same SW as scenario 4, rst_n pulled low in SR1 -> no second write, word 0x11 unchanged, rsp_valid never rises, req_ready=1 after release.
6. Wrap and back-to-back: LW at byte addr 0x3FFE with N=12 (word index 0xFFF) -> second read at mem_a=0. With req_valid held high, req_ready=0 throughout the transaction and the next request is accepted the cycle after RESP.
